// File: rtl/store_buffer.sv
// store_buffer
//   Small write buffer between the MEM stage and data memory. Stores with at
//   least one byte lane enabled are queued in a DEPTH-entry FIFO and drained
//   to memory one at a time through a request/acknowledge handshake. Stores
//   with no lanes enabled are discarded. A concurrent load address is compared
//   against every pending word so the pipeline can stall on a RAW hazard.
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   StoreValid          store request from the MEM stage
//   StoreAddr           store byte address (bits [31:2] kept)
//   FixedData           lane-aligned store data
//   MemoryByteSel       byte lane enables; 4'b0000 means "drop this store"
//   StoreReady          buffer not full
//   LoadAddr            concurrent load address (bits [31:2] compared)
//   LoadHazard          some pending store targets LoadAddr's word
//   Empty               nothing pending or in flight
//   MemReq              write request to data memory
//   MemAddr             word address of the head entry (zero when idle)
//   MemWData            write data of the head entry (zero when idle)
//   MemByteEn           byte enables of the head entry (zero when idle)
//   MemAck              memory accepted the current request this cycle
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        StoreValid,
    input  logic [31:0] StoreAddr,
    input  logic [31:0] FixedData,
    input  logic [3:0]  MemoryByteSel,
    output logic        StoreReady,
    input  logic [31:0] LoadAddr,
    output logic        LoadHazard,
    output logic        Empty,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic        MemAck
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state, next_state;

    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          push;
    logic          pop;

    // Address offset bits are not part of the word match.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{StoreAddr[1:0], LoadAddr[1:0]};

    assign StoreReady = (count != CW'(DEPTH));
    assign Empty      = (count == '0);
    assign MemReq     = (state == REQ);
    assign push       = StoreValid && StoreReady && (MemoryByteSel != '0);
    assign pop        = MemReq && MemAck;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
        end else begin
            count <= count_next;
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: only entries inside [rd_ptr, rd_ptr+count) are
    // ever observed.
    always_ff @(posedge Clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= StoreAddr[31:2];
            data_mem[wr_ptr] <= FixedData;
            be_mem[wr_ptr]   <= MemoryByteSel;
        end
    end

    // The FSM looks at the post-edge count so a store pushed into an empty
    // buffer is requested in the very next cycle, and back-to-back acks keep
    // the request asserted while entries remain.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (count_next != '0) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (pop) begin
                    next_state = (count_next != '0) ? REQ : IDLE;
                end else if (count == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        MemAddr   = '0;
        MemWData  = '0;
        MemByteEn = '0;
        if (MemReq) begin
            MemAddr   = {addr_mem[rd_ptr], 2'b00};
            MemWData  = data_mem[rd_ptr];
            MemByteEn = be_mem[rd_ptr];
        end
    end

    // An entry is live when its distance from the read pointer (mod DEPTH)
    // is below count; this includes the in-flight head.
    always_comb begin
        logic [PW-1:0] offset;
        LoadHazard = 1'b0;
        offset     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr;
            if ((CW'(offset) < count) && (addr_mem[i] == LoadAddr[31:2])) begin
                LoadHazard = 1'b1;
            end
        end
    end

endmodule
